// File: rtl/intr_host_agent.sv
// Host-side interrupt agent: programs the controller mode after reset, runs the
// two-stage acknowledge handshake, validates the vector, hands off to the ISR engine and returns EOI.
module intr_host_agent #(
  parameter int ACK_DELAY   = 6,
  parameter int VEC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        mode_i,
  input  logic [23:0] prio_order_i,
  input  logic        intr_out_i,
  input  logic        bus_oe_i,
  input  logic [7:0]  bus_in,
  output logic        intr_ack_n,
  output logic [7:0]  bus_out,
  output logic        bus_out_en,
  output logic        isr_valid,
  output logic [2:0]  isr_id,
  input  logic        isr_done,
  output logic        err,
  output logic [7:0]  served_cnt
);

  localparam logic [3:0] S_CFG   = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_WAIT1 = 4'd2;
  localparam logic [3:0] S_ACK1  = 4'd3;
  localparam logic [3:0] S_VEC   = 4'd4;
  localparam logic [3:0] S_WAIT2 = 4'd5;
  localparam logic [3:0] S_ACK2  = 4'd6;
  localparam logic [3:0] S_ISR   = 4'd7;
  localparam logic [3:0] S_EOI   = 4'd8;
  localparam logic [3:0] S_GAP   = 4'd9;

  localparam logic [7:0] ACK_D8 = 8'(ACK_DELAY);
  localparam logic [7:0] VTO_D8 = 8'(VEC_TIMEOUT);

  logic [3:0]  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_idx;
  logic        r_mode;
  logic [23:0] r_prio;
  logic        r_ack_n;
  logic [7:0]  r_bus_out;
  logic        r_isr_valid;
  logic [2:0]  r_isr_id;
  logic        r_err;
  logic [7:0]  r_served;

  logic        w_mode;
  logic [23:0] w_prio;
  logic [7:0]  w_cfg_word;
  logic [4:0]  w_vec_hdr;
  logic [4:0]  w_eoi_hdr;

  // First CFG cycle uses the live inputs; that edge is also when they get latched.
  assign w_mode    = (r_idx == 2'd0) ? mode_i       : r_mode;
  assign w_prio    = (r_idx == 2'd0) ? prio_order_i : r_prio;
  assign w_vec_hdr = r_mode ? 5'b10011 : 5'b01011;
  assign w_eoi_hdr = r_mode ? 5'b01100 : 5'b10100;

  always_comb begin
    w_cfg_word = 8'h00;
    case (r_idx)
      2'd0:    w_cfg_word = {w_prio[23:18], 2'b10};
      2'd1:    w_cfg_word = {w_prio[17:12], 2'b10};
      2'd2:    w_cfg_word = {w_prio[11:6],  2'b10};
      default: w_cfg_word = {w_prio[5:0],   2'b10};
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_CFG;
      r_cnt       <= 8'd0;
      r_idx       <= 2'd0;
      r_mode      <= 1'b0;
      r_prio      <= 24'd0;
      r_ack_n     <= 1'b1;
      r_bus_out   <= 8'h00;
      r_isr_valid <= 1'b0;
      r_isr_id    <= 3'd0;
      r_err       <= 1'b0;
      r_served    <= 8'd0;
    end else begin
      r_ack_n <= 1'b1;
      case (r_state)
        S_CFG: begin
          if (r_idx == 2'd0) begin
            r_mode <= mode_i;
            r_prio <= prio_order_i;
          end
          if (bus_oe_i) r_err <= 1'b1;
          if (!w_mode) begin
            r_bus_out <= 8'h01;
            r_state   <= S_IDLE;
          end else begin
            r_bus_out <= w_cfg_word;
            r_idx     <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_IDLE;
          end
        end
        S_IDLE: if (intr_out_i) begin
          r_state <= S_WAIT1;
          r_cnt   <= ACK_D8;
        end
        S_WAIT1: if (r_cnt == 8'd1) begin
          r_state <= S_ACK1;
          r_ack_n <= 1'b0;
        end else r_cnt <= r_cnt - 8'd1;
        S_ACK1: begin
          r_state <= S_VEC;
          r_cnt   <= VTO_D8;
        end
        S_VEC: begin
          if (bus_oe_i) begin
            if (bus_in[7:3] == w_vec_hdr) begin
              r_isr_id <= bus_in[2:0];
              r_state  <= S_WAIT2;
              r_cnt    <= ACK_D8;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (r_cnt == 8'd1) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt - 8'd1;
        end
        S_WAIT2: if (r_cnt == 8'd1) begin
          r_state <= S_ACK2;
          r_ack_n <= 1'b0;
        end else r_cnt <= r_cnt - 8'd1;
        S_ACK2: begin
          r_state     <= S_ISR;
          r_isr_valid <= 1'b1;
        end
        S_ISR: if (isr_done) begin
          r_isr_valid <= 1'b0;
          r_bus_out   <= {w_eoi_hdr, r_isr_id};
          r_ack_n     <= 1'b0;
          r_state     <= S_EOI;
        end
        S_EOI: begin
          if (bus_oe_i) r_err <= 1'b1;
          r_served <= r_served + 8'd1;
          r_cnt    <= 8'd2;
          r_state  <= S_GAP;
        end
        S_GAP: if (r_cnt == 8'd1) r_state <= S_IDLE;
               else r_cnt <= r_cnt - 8'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign intr_ack_n = r_ack_n;
  assign bus_out    = r_bus_out;
  assign bus_out_en = ~bus_oe_i;
  assign isr_valid  = r_isr_valid;
  assign isr_id     = r_isr_id;
  assign err        = r_err;
  assign served_cnt = r_served;

endmodule
